// File: rtl/memwb_skid_stage.sv
// rtl/memwb_skid_stage.sv - MEM/WB pipeline register with two-entry skid buffer and flush
//
// Purpose: registers ALU result, load data and writeback control between the
// memory stage and writeback. A second (skid) entry absorbs the one input that
// can arrive in the cycle the output stalls. As a result, in_ready is a pure flop
// and never depends combinationally on out_ready.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   flush               synchronous discard of all held entries
//   in_valid/in_ready   upstream handshake
//   alu_in, mem_data_in, control_in   upstream payload
//   out_valid/out_ready downstream handshake
//   alu_out, mem_data_out, control_out   registered payload (control masked on bubbles)
//   occupancy           held entries, 0..2
module memwb_skid_stage #(
  parameter int DATA_WIDTH    = 64,
  parameter int CONTROL_WIDTH = 16,
  parameter bit MASK_CTRL     = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    alu_in,
  input  logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic [CONTROL_WIDTH-1:0] control_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    alu_out,
  output logic [DATA_WIDTH-1:0]    mem_data_out,
  output logic [CONTROL_WIDTH-1:0] control_out,
  output logic [1:0]               occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                   state;
  logic                     main_valid;
  logic                     skid_valid;
  logic [DATA_WIDTH-1:0]    main_alu;
  logic [DATA_WIDTH-1:0]    main_mem;
  logic [CONTROL_WIDTH-1:0] main_ctrl;
  logic [DATA_WIDTH-1:0]    skid_alu;
  logic [DATA_WIDTH-1:0]    skid_mem;
  logic [CONTROL_WIDTH-1:0] skid_ctrl;

  logic accept;
  logic fire;

  assign accept = in_valid & in_ready;
  assign fire   = main_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_alu   <= '0;
      main_mem   <= '0;
      main_ctrl  <= '0;
      skid_alu   <= '0;
      skid_mem   <= '0;
      skid_ctrl  <= '0;
    end else if (flush) begin
      // Only the valid bits clear; payload keeps its last value so the
      // data outputs hold steady across the bubble.
      state      <= EMPTY;
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            main_alu   <= alu_in;
            main_mem   <= mem_data_in;
            main_ctrl  <= control_in;
            main_valid <= 1'b1;
            state      <= ONE;
          end
        end
        ONE: begin
          if (accept && fire) begin
            main_alu  <= alu_in;
            main_mem  <= mem_data_in;
            main_ctrl <= control_in;
          end else if (accept) begin
            // Output stalled: park the new entry behind main.
            skid_alu   <= alu_in;
            skid_mem   <= mem_data_in;
            skid_ctrl  <= control_in;
            skid_valid <= 1'b1;
            state      <= TWO;
          end else if (fire) begin
            main_valid <= 1'b0;
            state      <= EMPTY;
          end
        end
        TWO: begin
          if (fire) begin
            main_alu   <= skid_alu;
            main_mem   <= skid_mem;
            main_ctrl  <= skid_ctrl;
            skid_valid <= 1'b0;
            state      <= ONE;
          end
        end
        default: begin
          state      <= EMPTY;
          main_valid <= 1'b0;
          skid_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = ~skid_valid;
  assign out_valid    = main_valid;
  assign occupancy    = state;
  assign alu_out      = main_alu;
  assign mem_data_out = main_mem;

  // Writeback must never see stale control on a bubble when masking is on.
  assign control_out = MASK_CTRL ? (main_ctrl & {CONTROL_WIDTH{main_valid}}) : main_ctrl;

endmodule

// File: tb/tb_memwb_skid_stage.sv
// tb/tb_memwb_skid_stage.sv - self-checking bench for memwb_skid_stage against a queue model
module tb_memwb_skid_stage;

  localparam int DW = 64;
  localparam int CW = 16;

  typedef struct packed {
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [CW-1:0] ctrl;
  } entry_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] alu_in;
  logic [DW-1:0] mem_data_in;
  logic [CW-1:0] control_in;

  logic          in_ready_m, out_valid_m;
  logic [DW-1:0] alu_out_m, mem_data_out_m;
  logic [CW-1:0] control_out_m;
  logic [1:0]    occupancy_m;

  logic          in_ready_u, out_valid_u;
  logic [DW-1:0] alu_out_u, mem_data_out_u;
  logic [CW-1:0] control_out_u;
  logic [1:0]    occupancy_u;

  always #5 clk = ~clk;

  memwb_skid_stage #(.DATA_WIDTH(DW), .CONTROL_WIDTH(CW), .MASK_CTRL(1'b1)) dut_mask (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_m),
    .alu_in(alu_in), .mem_data_in(mem_data_in), .control_in(control_in),
    .out_valid(out_valid_m), .out_ready(out_ready),
    .alu_out(alu_out_m), .mem_data_out(mem_data_out_m), .control_out(control_out_m),
    .occupancy(occupancy_m)
  );

  memwb_skid_stage #(.DATA_WIDTH(DW), .CONTROL_WIDTH(CW), .MASK_CTRL(1'b0)) dut_nomask (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_u),
    .alu_in(alu_in), .mem_data_in(mem_data_in), .control_in(control_in),
    .out_valid(out_valid_u), .out_ready(out_ready),
    .alu_out(alu_out_u), .mem_data_out(mem_data_out_u), .control_out(control_out_u),
    .occupancy(occupancy_u)
  );

  int n_total = 0;
  int n_pass  = 0;

  // Model: the stage is a FIFO of at most two entries; the head is on the
  // outputs, and the data outputs show the last head ever presented.
  entry_t model_q[$];
  entry_t last_head;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
  endtask

  task automatic check_model();
    logic [CW-1:0] ctrl_exp;
    ctrl_exp = (model_q.size() > 0) ? last_head.ctrl : '0;
    check_eq("in_ready",     DW'(in_ready_m),     DW'(model_q.size() < 2));
    check_eq("out_valid",    DW'(out_valid_m),    DW'(model_q.size() > 0));
    check_eq("occupancy",    DW'(occupancy_m),    DW'(model_q.size()));
    check_eq("alu_out",      alu_out_m,           last_head.alu);
    check_eq("mem_data_out", mem_data_out_m,      last_head.mem);
    check_eq("control_mask", DW'(control_out_m),  DW'(ctrl_exp));
    check_eq("control_hold", DW'(control_out_u),  DW'(last_head.ctrl));
    check_eq("nomask_occ",   DW'(occupancy_u),    DW'(model_q.size()));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input logic r, input logic f, input logic v, input logic [DW-1:0] a,
                      input logic [DW-1:0] m, input logic [CW-1:0] c, input logic o);
    entry_t e;
    bit acc, fire;
    reset = r; flush = f; in_valid = v; alu_in = a; mem_data_in = m; control_in = c; out_ready = o;
    e.alu = a; e.mem = m; e.ctrl = c;
    acc  = v && (model_q.size() < 2);
    fire = o && (model_q.size() > 0);
    @(posedge clk); #1;
    if (r) begin
      model_q.delete();
      last_head = '0;
    end else if (f) begin
      model_q.delete();
    end else begin
      if (fire) void'(model_q.pop_front());
      if (acc) model_q.push_back(e);
    end
    if (model_q.size() > 0) last_head = model_q[0];
    check_model();
  endtask

  task automatic idle(input logic o);
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, o);
  endtask

  task automatic push(input logic [DW-1:0] a, input logic [CW-1:0] c, input logic o);
    step(1'b0, 1'b0, 1'b1, a, ~a, c, o);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_in = '0; mem_data_in = '0; control_in = '0;
    last_head = '0;

    // Reset state
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    check_eq("rst_in_ready",  DW'(in_ready_m),    DW'(1));
    check_eq("rst_out_valid", DW'(out_valid_m),   DW'(0));
    check_eq("rst_occ",       DW'(occupancy_m),   DW'(0));
    check_eq("rst_alu",       alu_out_m,          DW'(0));
    check_eq("rst_ctrl",      DW'(control_out_u), DW'(0));

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) begin
      push(DW'(i), CW'(i), 1'b1);
      check_eq("stream_alu", alu_out_m, DW'(i));
      check_eq("stream_occ", DW'(occupancy_m), DW'(1));
    end
    idle(1'b1);
    check_eq("stream_drain", DW'(out_valid_m), DW'(0));

    // Backpressure: A, B taken, C held off
    push(64'h11, 16'h1, 1'b0);
    push(64'h22, 16'h2, 1'b0);
    check_eq("bp_occ",      DW'(occupancy_m), DW'(2));
    check_eq("bp_in_ready", DW'(in_ready_m),  DW'(0));
    push(64'h33, 16'h3, 1'b0);
    check_eq("bp_hold_alu", alu_out_m, DW'(64'h11));
    out_ready = 1'b1; #1;
    check_eq("bp_no_comb_path", DW'(in_ready_m), DW'(0));
    push(64'h33, 16'h3, 1'b1);
    check_eq("bp_second", alu_out_m, DW'(64'h22));
    check_eq("bp_release_ready", DW'(in_ready_m), DW'(1));
    push(64'h33, 16'h3, 1'b1);
    check_eq("bp_third", alu_out_m, DW'(64'h33));
    out_ready = 1'b0; #1;
    check_eq("one_no_comb_path", DW'(in_ready_m), DW'(1));
    idle(1'b1);
    check_eq("bp_drain", DW'(out_valid_m), DW'(0));

    // Flush while holding two, with D presented in the flush cycle
    push(64'h55, 16'h5, 1'b0);
    push(64'h66, 16'h6, 1'b0);
    step(1'b0, 1'b1, 1'b1, 64'h44, 64'h44, 16'h4, 1'b0);
    check_eq("fl_out_valid", DW'(out_valid_m), DW'(0));
    check_eq("fl_occ",       DW'(occupancy_m), DW'(0));
    check_eq("fl_in_ready",  DW'(in_ready_m),  DW'(1));
    check_eq("fl_alu_hold",  alu_out_m,        DW'(64'h55));
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check_eq("fl_no_d", DW'(out_valid_m), DW'(0));
    end

    // Bubble masking
    push(64'h77, 16'hFFFF, 1'b1);
    check_eq("mask_live", DW'(control_out_m), DW'(16'hFFFF));
    idle(1'b1);
    idle(1'b0);
    check_eq("mask_bubble",  DW'(control_out_m), DW'(0));
    check_eq("nomask_hold",  DW'(control_out_u), DW'(16'hFFFF));
    check_eq("mask_alu_hold", alu_out_m,         DW'(64'h77));

    // Reset beats flush in TWO
    push(64'h88, 16'h8, 1'b0);
    push(64'h99, 16'h9, 1'b0);
    step(1'b1, 1'b1, 1'b1, 64'hAA, 64'hAA, 16'hA, 1'b0);
    check_eq("rf_occ",      DW'(occupancy_m),   DW'(0));
    check_eq("rf_alu",      alu_out_m,          DW'(0));
    check_eq("rf_mem",      mem_data_out_u,     DW'(0));
    check_eq("rf_ctrl",     DW'(control_out_u), DW'(0));
    check_eq("rf_in_ready", DW'(in_ready_m),    DW'(1));

    // Mid-stream reset leaves nothing behind
    push(64'hB1, 16'hB, 1'b0);
    push(64'hB2, 16'hB, 1'b1);
    step(1'b1, 1'b0, 1'b1, 64'hB3, 64'hB3, 16'hB, 1'b1);
    idle(1'b1);
    check_eq("mr_empty", DW'(out_valid_m), DW'(0));

    // Random traffic against the queue model
    for (int cyc = 0; cyc < 10000; cyc++) begin
      step(($urandom_range(0, 499) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 3) != 0),
           {$urandom, $urandom}, {$urandom, $urandom}, CW'($urandom),
           ($urandom_range(0, 1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/memwb_skid_stage.md
# memwb_skid_stage

Parametrised MEM/WB pipeline stage register with valid/ready flow control, a two-entry skid buffer and synchronous flush. It sits between the memory stage and writeback and carries the ALU result, the load data and the control word. Stalls propagate upstream with no combinational path from `out_ready` to `in_ready`. Bubbles are masked so writeback never sees stale control.

## Interface
- `DATA_WIDTH`, 64, width of `alu_*` and `mem_data_*`.
- `CONTROL_WIDTH`, 16, width of `control_*`.
- `MASK_CTRL`, 1, when 1, `control_out` is forced to 0 while `out_valid`=0.

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high.
- `flush`  in  1  synchronous; discards all held entries.
- `in_valid`  in  1  upstream entry present.
- `in_ready`  out  1  stage can accept an entry this cycle.
- `alu_in`  in  DATA_WIDTH  ALU result.
- `mem_data_in`  in  DATA_WIDTH  load data.
- `control_in`  in  CONTROL_WIDTH  writeback control.
- `out_valid`  out  1  `*_out` holds a valid entry.
- `out_ready`  in  1  downstream consumes the entry.
- `alu_out`  out  DATA_WIDTH  registered ALU result.
- `mem_data_out`  out  DATA_WIDTH  registered load data.
- `control_out`  out  CONTROL_WIDTH  registered control, masked per `MASK_CTRL`.
- `occupancy`  out  2  number of held entries, 0..2.

## Operation
- Storage has two entries:
  - main: drives the outputs.
  - skid: a second entry that catches input accepted while the output is stalled.
- Handshake definitions:
  - accept = `in_valid` & `in_ready`.
  - fire = `out_valid` & `out_ready`.
- States and transitions, evaluated with flush=0:
  - EMPTY (occ 0): on accept, load main and go to ONE. Otherwise stay in EMPTY.
  - ONE (occ 1):
    - accept & fire: reload main from the input; stay in ONE.
    - accept & !fire: load skid; go to TWO.
    - !accept & fire: go to EMPTY.
    - Neither: hold.
  - TWO (occ 2): `in_ready`=0. On fire, move skid to main and go to ONE. Otherwise hold.
- Output and occupancy encoding:
  - `in_ready` = !skid_valid. It is a registered signal, so it is 1 in EMPTY and ONE and 0 in TWO.
  - `out_valid` = main_valid.
  - `occupancy` is the registered state encoding: EMPTY=0, ONE=1, TWO=2. The value 3 never occurs.
- Flush has priority over every handshake:
  - Next state is EMPTY.
  - An input presented in the flush cycle is dropped.
  - A fire in the flush cycle still counts as consumed downstream.
  - Payload registers keep their values on flush; only the valid bits clear.
- Reset clears the valid bits and all payload registers to 0. Reset has priority over flush.
- When main is invalid, `alu_out` and `mem_data_out` hold their last value. `control_out` is 0 if `MASK_CTRL`=1, otherwise it holds its last value.
- Ordering is strict FIFO. No entry is duplicated or reordered.

## Timing
- Reset values:
  - `in_ready`=1 (the skid entry is empty).
  - `out_valid`=0, `occupancy`=0.
  - `alu_out`, `mem_data_out`, `control_out` = 0.
- Latency and throughput:
  - An entry accepted on edge N appears on the outputs after edge N, i.e. one cycle of latency.
  - Sustained throughput is 1 entry/cycle while `out_ready`=1.
- Stall behaviour:
  - When `out_ready` drops, at most one more entry is accepted; it goes into skid.
  - `in_ready` falls after the edge that fills skid.
- Release from TWO: `out_ready`=1 for one cycle moves skid to main, and `in_ready` rises after that edge.
- All outputs are driven directly from flops. The only combinational logic on an output is the `MASK_CTRL` AND gate.
- Reset or flush asserted mid-stall in TWO: the state is EMPTY and `in_ready`=1 after the edge.

## Test plan
- Reset then stream: feed alu 1..8 with `out_ready`=1 → outputs 1..8 on consecutive cycles, each 1 cycle after input; `occupancy` stays 1.
- Backpressure: present A=0x11, B=0x22, C=0x33 back-to-back with `out_ready`=0 → A and B accepted, `in_ready`=0 while C is held, `occupancy`=2. Raise `out_ready` → outputs A, B, C in order with no loss.
- Flush in TWO: hold two entries, assert `flush` with `in_valid`=1 (D=0x44) → next cycle `out_valid`=0, `occupancy`=0, `in_ready`=1, and D is never output.
- Bubble masking: `control_in`=0xFFFF accepted, then consumed, then idle → `control_out`=0 once `out_valid`=0, while `alu_out` holds its last value. With `MASK_CTRL`=0, `control_out` holds 0xFFFF.
- Reset vs flush: assert reset with `flush`=1 in state TWO → all outputs 0 and `occupancy`=0. A mid-stream reset leaves no residual entries after release.
- Random valid/ready stimulus for 10k cycles against a scoreboard → in-order, lossless, no duplicates; `in_ready` never depends combinationally on `out_ready`.
